prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 17 +
 rtl/word_packer.sv | 38 +++
 rtl/prog_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The header is a 16-bit little-endian word count; words arrive LSB first.
package loader_pkg;

   typedef enum logic [2:0] {
      CNT_LO = 3'd0,
      CNT_HI = 3'd1,
      DATA   = 3'd2,
      CSUM   = 3'd3,
      DONE   = 3'd4,
      ERROR  = 3'd5
   } state_e;

   localparam int HDR_BYTES = 2;
   localparam int BPW       = 4;

endpackage

// File: rtl/word_packer.sv
// Collects LSB-first bytes into a 32-bit word; word_valid_o fires combinationally
// with the 4th byte so the loader can register the write on that same edge.
module word_packer
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        byte_en_i,
   input  logic [1:0]  byte_pos_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   logic [23:0] buf_q;
   logic [23:0] buf_d;

   always_comb begin
      buf_d = buf_q;
      if (byte_en_i) begin
         case (byte_pos_i)
            2'd0:    buf_d[7:0]   = byte_i;
            2'd1:    buf_d[15:8]  = byte_i;
            2'd2:    buf_d[23:16] = byte_i;
            default: buf_d        = buf_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) buf_q <= '0;
      else        buf_q <= buf_d;
   end

   assign word_valid_o = byte_en_i && (byte_pos_i == 2'(BPW - 1));
   assign word_o       = {byte_i, buf_q};

endmodule

// File: rtl/prog_loader.sv
// Streams a counted, XOR-checksummed program image into instruction memory and
// releases the core from reset once the whole image has been verified.
module prog_loader
   import loader_pkg::*;
#(
   parameter int NUMWORDS  = 4096,
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 byte_valid_i,
   input  logic [7:0]           byte_data_i,
   output logic                 byte_ready_o,
   output logic                 we_o,
   output logic [31:0]          waddr_o,
   output logic [DATAWIDTH-1:0] wdata_o,
   output logic                 core_rst_o,
   output logic                 done_o,
   output logic                 err_o,
   output state_e               dbg_state_o
);

   if (DATAWIDTH != 32) begin : g_bad_width
      $error("prog_loader only supports DATAWIDTH = 32");
   end

   localparam logic [31:0] MAX_WORDS = NUMWORDS;

   // Handshake: a byte transfers on a rising edge where byte_valid_i and
   // byte_ready_o are both high; the loader never stalls a non-terminal state.
   state_e      state_q, state_d;
   logic [1:0]  pos_q, pos_d;
   logic [15:0] idx_q, idx_d;
   logic [7:0]  cnt_lo_q, cnt_lo_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  csum_q, csum_d;
   logic        ready_q, ready_d;
   logic        we_q, we_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] hdr_count;
   logic        accept;
   logic        word_valid;
   logic [31:0] word;

   assign accept = byte_valid_i && ready_q;

   word_packer u_packer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .byte_en_i    (accept && (state_q == DATA)),
      .byte_pos_i   (pos_q),
      .byte_i       (byte_data_i),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      idx_d     = idx_q;
      cnt_lo_d  = cnt_lo_q;
      count_d   = count_q;
      csum_d    = csum_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      hdr_count = {byte_data_i, cnt_lo_q};
      case (state_q)
         CNT_LO: if (accept) begin
            cnt_lo_d = byte_data_i;
            csum_d   = csum_q ^ byte_data_i;
            state_d  = CNT_HI;
         end
         CNT_HI: if (accept) begin
            count_d = hdr_count;
            csum_d  = csum_q ^ byte_data_i;
            if (hdr_count == 16'd0)                   state_d = CSUM;
            else if ({16'd0, hdr_count} > MAX_WORDS) state_d = ERROR;
            else                                      state_d = DATA;
         end
         DATA: if (accept) begin
            csum_d = csum_q ^ byte_data_i;
            pos_d  = pos_q + 2'd1;
            if (word_valid) begin
               we_d    = 1'b1;
               waddr_d = {14'd0, idx_q, 2'b00};
               wdata_d = word;
               idx_d   = idx_q + 16'd1;
               if (idx_q == count_q - 16'd1) state_d = CSUM;
            end
         end
         CSUM: if (accept) begin
            state_d = (byte_data_i == csum_q) ? DONE : ERROR;
         end
         default: state_d = state_q;
      endcase
      ready_d = (state_d != DONE) && (state_d != ERROR);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= CNT_LO;
         pos_q    <= '0;
         idx_q    <= '0;
         cnt_lo_q <= '0;
         count_q  <= '0;
         csum_q   <= '0;
         ready_q  <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         idx_q    <= idx_d;
         cnt_lo_q <= cnt_lo_d;
         count_q  <= count_d;
         csum_q   <= csum_d;
         ready_q  <= ready_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign byte_ready_o = ready_q;
   assign we_o         = we_q;
   assign waddr_o      = waddr_q;
   assign wdata_o      = wdata_q;
   assign done_o       = (state_q == DONE);
   assign err_o        = (state_q == ERROR);
   assign core_rst_o   = (state_q == DONE);
   assign dbg_state_o  = state_q;

endmodule
